alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 15 +
 rtl/seq_decode.sv | 25 ++
 rtl/alu_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state/class enums, opcodes and instruction field positions
package alu_seq_pkg;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT} state_t;
   typedef enum logic [2:0] {C_ALU, C_LDI, C_JMP, C_BZ, C_HALT, C_NOP} iclass_t;
   localparam logic [3:0] OPC_LDI  = 4'h8;
   localparam logic [3:0] OPC_JMP  = 4'h9;
   localparam logic [3:0] OPC_BZ   = 4'hA;
   localparam logic [3:0] OPC_HALT = 4'hF;
   localparam int OPC_LSB = 12;
   localparam int RD_LSB  = 9;
   localparam int RS1_LSB = 6;
   localparam int RS2_LSB = 3;
   localparam int IMM_LSB = 0;
   localparam int FLAG_Z  = 1;
endpackage

// File: rtl/seq_decode.sv
// seq_decode: splits the instruction register into class and operand fields
module seq_decode
   import alu_seq_pkg::*;
(
   input  logic [15:0] i_ir,
   output iclass_t     o_class,
   output logic [2:0]  o_rd,
   output logic [2:0]  o_rs1,
   output logic [2:0]  o_rs2,
   output logic [2:0]  o_alu_op,
   output logic [7:0]  o_imm8
);
   logic [3:0] w_opc;
   assign w_opc    = i_ir[OPC_LSB +: 4];
   assign o_rd     = i_ir[RD_LSB +: 3];
   assign o_rs1    = i_ir[RS1_LSB +: 3];
   assign o_rs2    = i_ir[RS2_LSB +: 3];
   assign o_imm8   = i_ir[IMM_LSB +: 8];
   assign o_alu_op = w_opc[2:0];
   assign o_class  = !w_opc[3]          ? C_ALU  :
                     w_opc == OPC_LDI   ? C_LDI  :
                     w_opc == OPC_JMP   ? C_JMP  :
                     w_opc == OPC_BZ    ? C_BZ   :
                     w_opc == OPC_HALT  ? C_HALT : C_NOP;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute/writeback controller for an external ALU and register file
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter logic [7:0] PC_RESET = 8'h00,
   parameter int         MAX_WAIT = 15
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   output logic [7:0]  o_mem_addr,
   output logic        o_mem_rd,
   input  logic [15:0] i_mem_rdata,
   input  logic        i_mem_ready,
   output logic [2:0]  o_rf_rd_addr_a,
   output logic [2:0]  o_rf_rd_addr_b,
   input  logic [7:0]  i_rf_rd_data_a,
   input  logic [7:0]  i_rf_rd_data_b,
   output logic        o_rf_wr_en,
   output logic [2:0]  o_rf_wr_addr,
   output logic [7:0]  o_rf_wr_data,
   output logic [7:0]  o_alu_a,
   output logic [7:0]  o_alu_b,
   output logic [2:0]  o_alu_op,
   input  logic [7:0]  i_alu_result,
   input  logic [3:0]  i_alu_nzcv,
   output logic [3:0]  o_flags,
   output logic        o_busy,
   output logic        o_halted,
   output logic        o_fetch_err
);
   localparam int WW = $clog2(MAX_WAIT + 2);
   state_t          r_state, w_state_nx;
   logic [7:0]      r_pc;
   logic [15:0]     r_ir;
   logic [7:0]      r_res;
   logic [3:0]      r_nzcv;
   logic [3:0]      r_flags;
   logic            r_fetch_err;
   logic [WW-1:0]   r_wait;
   iclass_t         w_class;
   logic [2:0]      w_rd, w_rs1, w_rs2, w_alu_op;
   logic [7:0]      w_imm8;
   logic            w_wait_done;
   seq_decode u_dec (
      .i_ir     (r_ir),
      .o_class  (w_class),
      .o_rd     (w_rd),
      .o_rs1    (w_rs1),
      .o_rs2    (w_rs2),
      .o_alu_op (w_alu_op),
      .o_imm8   (w_imm8)
   );
   assign w_wait_done = r_wait == WW'(MAX_WAIT);
   // status is forced low while reset is held so a mid-instruction reset shows nothing
   assign o_mem_addr  = r_pc;
   assign o_busy      = i_rst_n && (r_state inside {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK});
   assign o_halted    = i_rst_n && r_state == S_HALT;
   assign o_flags     = i_rst_n ? r_flags : 4'd0;
   assign o_fetch_err = i_rst_n && r_fetch_err;
   always_ff @(posedge i_clk)
      r_state <= !i_rst_n ? S_IDLE : w_state_nx;
   always_comb begin
      w_state_nx     = r_state;
      o_mem_rd       = 1'b0;
      o_rf_rd_addr_a = '0;
      o_rf_rd_addr_b = '0;
      o_rf_wr_en     = 1'b0;
      o_rf_wr_addr   = '0;
      o_rf_wr_data   = '0;
      o_alu_a        = '0;
      o_alu_b        = '0;
      o_alu_op       = '0;
      if (i_rst_n) begin
         case (r_state)
            S_IDLE, S_HALT: w_state_nx = i_start ? S_FETCH : r_state;
            S_FETCH: begin
               o_mem_rd   = 1'b1;
               w_state_nx = i_mem_ready ? S_DECODE : w_wait_done ? S_HALT : S_FETCH;
            end
            S_DECODE: begin
               o_rf_rd_addr_a = w_rs1;
               o_rf_rd_addr_b = w_rs2;
               w_state_nx     = w_class == C_ALU  ? S_EXECUTE   :
                                w_class == C_LDI  ? S_WRITEBACK :
                                w_class == C_HALT ? S_HALT      : S_FETCH;
            end
            S_EXECUTE: begin
               o_rf_rd_addr_a = w_rs1;
               o_rf_rd_addr_b = w_rs2;
               o_alu_a        = i_rf_rd_data_a;
               o_alu_b        = i_rf_rd_data_b;
               o_alu_op       = w_alu_op;
               w_state_nx     = S_WRITEBACK;
            end
            S_WRITEBACK: begin
               o_rf_wr_en   = 1'b1;
               o_rf_wr_addr = w_rd;
               o_rf_wr_data = w_class == C_ALU ? r_res : w_imm8;
               w_state_nx   = S_FETCH;
            end
            default: w_state_nx = S_IDLE;
         endcase
      end
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pc        <= PC_RESET;
         r_ir        <= '0;
         r_res       <= '0;
         r_nzcv      <= '0;
         r_flags     <= '0;
         r_fetch_err <= 1'b0;
         r_wait      <= '0;
      end else begin
         if (r_state == S_FETCH) begin
            if (i_mem_ready) begin
               r_ir   <= i_mem_rdata;
               r_pc   <= r_pc + 8'd1;
               r_wait <= '0;
            end else if (w_wait_done) begin
               r_fetch_err <= 1'b1;
               r_wait      <= '0;
            end else begin
               r_wait <= r_wait + WW'(1);
            end
         end
         if (r_state == S_DECODE && (w_class == C_JMP || (w_class == C_BZ && r_flags[FLAG_Z])))
            r_pc <= w_imm8;
         if (r_state == S_EXECUTE) begin
            r_res  <= i_alu_result;
            r_nzcv <= i_alu_nzcv;
         end
         if (r_state == S_WRITEBACK && w_class == C_ALU)
            r_flags <= r_nzcv;
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: memory/RF/ALU models around the sequencer with a write scoreboard
module tb_alu_sequencer;
   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [3:0] nzcv;
   } vec_t;
   typedef struct {
      logic [2:0] addr;
      logic [7:0] data;
      int         lat;
   } wr_t;
   logic        clk = 1'b0;
   logic        rst_n, start, mem_ready;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [15:0] mem_rdata;
   logic [2:0]  rd_a, rd_b;
   logic [7:0]  rd_data_a, rd_data_b;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [7:0]  alu_a, alu_b, alu_result;
   logic [2:0]  alu_op;
   logic [3:0]  alu_nzcv, flags;
   logic        busy, halted, fetch_err;
   logic [15:0] mem [256];
   logic [7:0]  rf [8];
   logic        pre_we = 1'b0;
   logic [2:0]  pre_addr = '0;
   logic [7:0]  pre_data = '0;
   int          cyc = 0;
   int          last_fetch = 0;
   logic [7:0]  last_faddr = '0;
   int          stalls = 0;
   wr_t         obs [64];
   int          obs_n = 0;
   int          obs_rd = 0;
   wr_t         sb [$];
   int          n_tests = 0;
   int          n_fail = 0;
   vec_t        tbl [8];
   logic [8:0]  sum;
   logic        ovf;

   alu_sequencer dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start        (start),
      .o_mem_addr     (mem_addr),
      .o_mem_rd       (mem_rd),
      .i_mem_rdata    (mem_rdata),
      .i_mem_ready    (mem_ready),
      .o_rf_rd_addr_a (rd_a),
      .o_rf_rd_addr_b (rd_b),
      .i_rf_rd_data_a (rd_data_a),
      .i_rf_rd_data_b (rd_data_b),
      .o_rf_wr_en     (wr_en),
      .o_rf_wr_addr   (wr_addr),
      .o_rf_wr_data   (wr_data),
      .o_alu_a        (alu_a),
      .o_alu_b        (alu_b),
      .o_alu_op       (alu_op),
      .i_alu_result   (alu_result),
      .i_alu_nzcv     (alu_nzcv),
      .o_flags        (flags),
      .o_busy         (busy),
      .o_halted       (halted),
      .o_fetch_err    (fetch_err)
   );

   always #5 clk = ~clk;
   assign mem_rdata = mem[mem_addr];
   assign rd_data_a = rf[rd_a];
   assign rd_data_b = rf[rd_b];

   // ALU: 0 ADD, 1 SUB (C = borrow), 2 AND, 3 OR, 4 XOR, others pass A
   always_comb begin
      sum = 9'd0;
      ovf = 1'b0;
      case (alu_op)
         3'd0: begin
            sum = {1'b0, alu_a} + {1'b0, alu_b};
            ovf = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
         end
         3'd1: begin
            sum = {1'b0, alu_a} - {1'b0, alu_b};
            ovf = (alu_a[7] != alu_b[7]) && (sum[7] != alu_a[7]);
         end
         3'd2: sum = {1'b0, alu_a & alu_b};
         3'd3: sum = {1'b0, alu_a | alu_b};
         3'd4: sum = {1'b0, alu_a ^ alu_b};
         default: sum = {1'b0, alu_a};
      endcase
      alu_result = sum[7:0];
      alu_nzcv   = {ovf, sum[8], sum[7:0] == 8'd0, sum[7]};
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (wr_en) rf[wr_addr] <= wr_data;
      else if (pre_we) rf[pre_addr] <= pre_data;
   end

   always @(negedge clk) begin
      if (mem_rd && mem_ready) begin
         last_fetch <= cyc;
         last_faddr <= mem_addr;
      end
      if (mem_rd && !mem_ready) stalls <= stalls + 1;
      if (wr_en && obs_n < 64) begin
         obs[obs_n] <= '{addr: wr_addr, data: wr_data, lat: cyc - last_fetch};
         obs_n <= obs_n + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drain(input string nm);
      wr_t e;
      while (obs_rd < obs_n) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_extra_write: got addr %0d data %0h expected no write", nm, obs[obs_rd].addr, obs[obs_rd].data);
         end else begin
            e = sb.pop_front();
            chk({nm, "_wr_addr"}, 32'(obs[obs_rd].addr), 32'(e.addr));
            chk({nm, "_wr_data"}, 32'(obs[obs_rd].data), 32'(e.data));
            chk({nm, "_wr_lat"}, 32'(obs[obs_rd].lat), 32'(e.lat));
         end
         obs_rd++;
      end
      chk({nm, "_pending_writes"}, 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
   endtask

   task automatic preload(input logic [2:0] a, input logic [7:0] d);
      @(posedge clk);
      #1 pre_we = 1'b1;
      pre_addr = a;
      pre_data = d;
      @(posedge clk);
      #1 pre_we = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      mem_ready = 1'b1;
      fill_mem();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("reset_ctrl", 32'({busy, halted, fetch_err, mem_rd, wr_en, flags}), 32'd0);
      chk("reset_mem_addr", 32'(mem_addr), 32'h00);
      chk("reset_dp", 32'({alu_a, alu_b, alu_op, rd_a, rd_b, wr_addr}), 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic go();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_halt(input string nm);
      int k = 0;
      while (!halted && k < 80) begin
         @(negedge clk);
         k++;
      end
      chk(nm, 32'(halted), 32'd1);
   endtask

   task automatic run_bz(input string nm, input logic [7:0] r2, input logic [7:0] r3,
                         input logic [3:0] exp_flags, input logic [7:0] exp_faddr);
      do_reset();
      mem[0] = 16'h8205;
      mem[1] = {8'h84, r2};
      mem[2] = 16'h1650;
      mem[3] = 16'hA040;
      sb.push_back('{addr: 3'd1, data: 8'h05, lat: 2});
      sb.push_back('{addr: 3'd2, data: r2, lat: 2});
      sb.push_back('{addr: 3'd3, data: r3, lat: 3});
      go();
      wait_halt({nm, "_halt"});
      chk({nm, "_flags"}, 32'(flags), 32'(exp_flags));
      chk({nm, "_last_fetch"}, 32'(last_faddr), 32'(exp_faddr));
      chk({nm, "_pc"}, 32'(mem_addr), 32'(exp_faddr + 8'd1));
      drain(nm);
   endtask

   initial begin
      int k;
      int s0;
      tbl[0] = '{op: 3'd0, a: 8'h7F, b: 8'h01, res: 8'h80, nzcv: 4'b1001};
      tbl[1] = '{op: 3'd0, a: 8'hFF, b: 8'h01, res: 8'h00, nzcv: 4'b0110};
      tbl[2] = '{op: 3'd1, a: 8'h05, b: 8'h05, res: 8'h00, nzcv: 4'b0010};
      tbl[3] = '{op: 3'd1, a: 8'h03, b: 8'h05, res: 8'hFE, nzcv: 4'b0101};
      tbl[4] = '{op: 3'd1, a: 8'h80, b: 8'h01, res: 8'h7F, nzcv: 4'b1000};
      tbl[5] = '{op: 3'd2, a: 8'hF0, b: 8'h3C, res: 8'h30, nzcv: 4'b0000};
      tbl[6] = '{op: 3'd3, a: 8'h0F, b: 8'h80, res: 8'h8F, nzcv: 4'b0001};
      tbl[7] = '{op: 3'd4, a: 8'hAA, b: 8'hAA, res: 8'h00, nzcv: 4'b0010};
      rst_n = 1'b0;
      start = 1'b0;
      mem_ready = 1'b1;
      fill_mem();
      // LDI R5,5 then HALT
      do_reset();
      mem[0] = 16'h8A05;
      sb.push_back('{addr: 3'd5, data: 8'h05, lat: 2});
      go();
      wait_halt("ldi_halt");
      chk("ldi_flags_kept", 32'(flags), 32'd0);
      drain("ldi");
      // ALU table: Rd=3, Rs1=1, Rs2=2
      for (int i = 0; i < 8; i++) begin
         do_reset();
         preload(3'd1, tbl[i].a);
         preload(3'd2, tbl[i].b);
         mem[0] = {1'b0, tbl[i].op, 3'd3, 3'd1, 3'd2, 3'd0};
         sb.push_back('{addr: 3'd3, data: tbl[i].res, lat: 3});
         go();
         wait_halt($sformatf("alu%0d_halt", i));
         chk($sformatf("alu%0d_flags", i), 32'(flags), 32'(tbl[i].nzcv));
         drain($sformatf("alu%0d", i));
      end
      run_bz("bz_taken", 8'h05, 8'h00, 4'b0010, 8'h40);
      run_bz("bz_not_taken", 8'h03, 8'h02, 4'b0000, 8'h04);
      // three wait cycles on the first fetch
      do_reset();
      mem[0] = 16'h8C33;
      mem_ready = 1'b0;
      sb.push_back('{addr: 3'd6, data: 8'h33, lat: 2});
      s0 = stalls;
      go();
      chk("stall_busy", 32'({busy, mem_rd}), 32'b11);
      repeat (3) @(posedge clk);
      #1 mem_ready = 1'b1;
      wait_halt("stall_halt");
      chk("stall_cycles", 32'(stalls - s0), 32'd3);
      drain("stall");
      // fetch abandoned after MAX_WAIT+1 cycles, error is sticky
      do_reset();
      mem_ready = 1'b0;
      s0 = stalls;
      go();
      wait_halt("timeout_halt");
      chk("timeout_err", 32'(fetch_err), 32'd1);
      chk("timeout_cycles", 32'(stalls - s0), 32'd16);
      chk("timeout_pc", 32'(mem_addr), 32'h00);
      mem_ready = 1'b1;
      go();
      wait_halt("timeout_resume_halt");
      chk("timeout_err_sticky", 32'(fetch_err), 32'd1);
      drain("timeout");
      // PC wrap and HALT resume
      do_reset();
      mem[0] = 16'h90FE;
      go();
      wait_halt("wrap_halt1");
      chk("wrap_pc_ff", 32'(mem_addr), 32'hFF);
      chk("halt_quiet", 32'({busy, mem_rd, wr_en}), 32'd0);
      mem[0] = 16'hF000;
      mem[8'hFF] = 16'hB000;
      go();
      wait_halt("wrap_halt2");
      chk("wrap_fetch_00", 32'(last_faddr), 32'h00);
      chk("wrap_pc_01", 32'(mem_addr), 32'h01);
      drain("wrap");
      // reset during WRITEBACK of an ALU op
      do_reset();
      preload(3'd1, 8'h7F);
      preload(3'd2, 8'h01);
      mem[0] = 16'h0650;
      mem[2] = 16'h0650;
      sb.push_back('{addr: 3'd3, data: 8'h80, lat: 3});
      go();
      wait_halt("rstwb_halt");
      chk("rstwb_flags_before", 32'(flags), 32'b1001);
      preload(3'd3, 8'hEE);
      go();
      k = 0;
      while (!(mem_rd && mem_ready) && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("rstwb_fetch_seen", 32'(mem_rd && mem_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rstwb_in_reset", 32'({wr_en, busy, flags}), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rstwb_idle", 32'({busy, halted, mem_rd, flags}), 32'd0);
      chk("rstwb_pc", 32'(mem_addr), 32'h00);
      chk("rstwb_rf_kept", 32'(rf[3]), 32'hEE);
      drain("rstwb");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
